// File: rtl/ft245_sync_bridge.sv
// ft245_sync_bridge: FT2232 FT245 synchronous FIFO master bridging the pins to rx/tx valid/ready byte streams.
// Optional feature macro: FT_SEND_IMMEDIATE_EN (drives fifo_siwu_o from tx_flush_i; otherwise siwu tied high).
module ft245_sync_bridge #(
    parameter int RX_SKID_DEPTH = 4,
    parameter int BURST_MAX     = 64
) (
    input  logic       fifo_clk_i,
    input  logic       reset_n_i,
    input  logic       fifo_rxf_n_i,
    input  logic       fifo_txe_n_i,
    input  logic [7:0] fifo_data_i,
    output logic [7:0] fifo_data_o,
    output logic       fifo_data_oe_o,
    output logic       fifo_oe_n_o,
    output logic       fifo_rd_n_o,
    output logic       fifo_wr_n_o,
    output logic       fifo_siwu_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       tx_flush_i
);
    localparam int AW = $clog2(RX_SKID_DEPTH);

    typedef enum logic [2:0] {IDLE, RD_OE, RD_BURST, RD_DRAIN, TURN, WR_BURST} state_t;

    state_t      state_q;
    logic        oe_n_q, rd_n_q, wr_n_q, data_oe_q, hv_q, hv_d, last_rx_q;
    logic [7:0]  data_o_q, data_o_d, cnt_q;
    logic [7:0]  mem_q [RX_SKID_DEPTH];
    logic [AW:0] wp_q, rp_q, fill;
    logic        push, pop, room, burst_ok, rd_req, rd_go, wr_req, accept, load, stay;

    // Skid occupancy; keeping two free slots covers the byte that can still land after rd_n is dropped.
    assign fill       = wp_q - rp_q;
    assign room       = fill <= (AW + 1)'(RX_SKID_DEPTH - 2);
    assign push       = !oe_n_q && !rd_n_q && !fifo_rxf_n_i;
    assign rx_valid_o = wp_q != rp_q;
    assign rx_data_o  = mem_q[rp_q[AW-1:0]];
    assign pop        = rx_valid_o && rx_ready_i;

    assign burst_ok = cnt_q < 8'(BURST_MAX);
    assign rd_req   = !fifo_rxf_n_i && room;
    assign rd_go    = rd_req && burst_ok;
    assign wr_req   = !fifo_txe_n_i && (hv_q || tx_valid_i);

    // data_o_q doubles as the tx holding register; a byte leaves it only when the FT2232 takes it.
    assign accept     = !wr_n_q && !fifo_txe_n_i;
    assign tx_ready_o = state_q == WR_BURST && (!hv_q || accept);
    assign load       = tx_ready_o && tx_valid_i;
    assign hv_d       = load || (hv_q && !accept);
    assign data_o_d   = load ? tx_data_i : data_o_q;
    assign stay       = hv_d && !fifo_txe_n_i && burst_ok;

    assign fifo_data_o    = data_o_q;
    assign fifo_data_oe_o = data_oe_q;
    assign fifo_oe_n_o    = oe_n_q;
    assign fifo_rd_n_o    = rd_n_q;
    assign fifo_wr_n_o    = wr_n_q;

    // Skid storage array, written at the push pointer.
    always_ff @(posedge fifo_clk_i) begin
        if (push) mem_q[wp_q[AW-1:0]] <= fifo_data_i;
    end

    // Skid pointers; natural wrap of the extra MSB distinguishes full from empty.
    always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_q + (AW + 1)'(push);
            rp_q <= rp_q + (AW + 1)'(pop);
        end
    end

    // Bus FSM with registered pin outputs, burst counting and round-robin arbitration.
    always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            oe_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
            data_o_q  <= 8'h00;
            hv_q      <= 1'b0;
            cnt_q     <= 8'h00;
            last_rx_q <= 1'b0;
        end else begin
            hv_q     <= hv_d;
            data_o_q <= data_o_d;
            case (state_q)
                IDLE: begin
                    if (rd_req && !(wr_req && last_rx_q)) begin
                        state_q   <= RD_OE;
                        oe_n_q    <= 1'b0;
                        cnt_q     <= 8'h00;
                        last_rx_q <= 1'b1;
                    end else if (wr_req) begin
                        state_q   <= WR_BURST;
                        data_oe_q <= 1'b1;
                        cnt_q     <= 8'h00;
                        last_rx_q <= 1'b0;
                    end
                end
                RD_OE, RD_BURST: begin
                    rd_n_q  <= !rd_go;
                    cnt_q   <= cnt_q + 8'(rd_go);
                    state_q <= (state_q == RD_OE || rd_go) ? RD_BURST : RD_DRAIN;
                end
                RD_DRAIN: begin
                    oe_n_q  <= 1'b1;
                    state_q <= TURN;
                end
                TURN: state_q <= IDLE;
                WR_BURST: begin
                    wr_n_q <= !stay;
                    cnt_q  <= cnt_q + 8'(stay);
                    if (!stay) begin
                        data_oe_q <= 1'b0;
                        state_q   <= TURN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FT_SEND_IMMEDIATE_EN
    logic flush_q, siwu_q, fire;

    // Fire at the end of a write burst, or straight away when idle with nothing left to send.
    assign fire = (flush_q || tx_flush_i) &&
                  ((state_q == WR_BURST && !stay) || (state_q == IDLE && !hv_q && !tx_valid_i));
    assign fifo_siwu_o = siwu_q;

    // Flush latch and one-cycle siwu pulse.
    always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            flush_q <= 1'b0;
            siwu_q  <= 1'b1;
        end else begin
            flush_q <= (flush_q || tx_flush_i) && !fire;
            siwu_q  <= !fire;
        end
    end
`else
    logic unused_flush;

    assign unused_flush = tx_flush_i;
    assign fifo_siwu_o  = 1'b1;
`endif

endmodule
